// File: rtl/seg_scan_mux.sv
// Time-multiplexed digit scanner: drives one-hot digit strobes and a shared
// segment bus from a per-frame snapshot of the digit patterns, with blanking gaps.
module seg_scan_mux #(
    parameter int w_digit     = 8,
    parameter int w_seg       = 8,
    parameter int show_cycles = 1000,
    parameter int dead_cycles = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [w_digit-1:0][w_seg-1:0]    hex,
    input  logic [w_digit-1:0]               digit_en,
    input  logic                             freeze,
    output logic [w_digit-1:0]               digit,
    output logic [w_seg-1:0]                 hgfedcba,
    output logic                             frame_start
);

    localparam int max_cycles = (show_cycles > dead_cycles) ? show_cycles : dead_cycles;
    localparam int cnt_w      = $clog2(max_cycles + 1);
    localparam int idx_w      = (w_digit > 1) ? $clog2(w_digit) : 1;
    localparam bit has_dead   = (dead_cycles > 0);

    localparam logic [cnt_w-1:0] show_last = cnt_w'(show_cycles - 1);
    localparam logic [cnt_w-1:0] dead_last = cnt_w'((dead_cycles > 0) ? dead_cycles - 1 : 0);
    localparam logic [cnt_w-1:0] cnt_one   = cnt_w'(1);
    localparam logic [idx_w-1:0] idx_last  = idx_w'(w_digit - 1);
    localparam logic [idx_w-1:0] idx_one   = idx_w'(1);

    typedef enum logic [1:0] {
        st_snap = 2'd0,
        st_show = 2'd1,
        st_dead = 2'd2
    } state_t;

    state_t                          state_r, state_s;
    logic [idx_w-1:0]                idx_r, idx_s;
    logic [cnt_w-1:0]                cnt_r, cnt_s;
    logic [w_digit-1:0][w_seg-1:0]   shadow_hex_r;
    logic [w_digit-1:0]              shadow_en_r;
    logic [w_digit-1:0]              digit_r, digit_s;
    logic [w_seg-1:0]                seg_r, seg_s;
    logic                            frame_start_r, frame_start_s;

    function automatic logic [w_digit-1:0] onehot_f(input logic [idx_w-1:0] i);
        logic [w_digit-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // State, slot index and dwell counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= st_snap;
            idx_r   <= '0;
            cnt_r   <= '0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next-state logic: dwell in each state, then advance slot or wrap to SNAP
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        cnt_s   = cnt_r + cnt_one;
        case (state_r)
            st_snap: begin
                state_s = st_show;
                idx_s   = '0;
                cnt_s   = '0;
            end
            st_show: begin
                if (cnt_r == show_last) begin
                    cnt_s = '0;
                    if (has_dead) begin
                        state_s = st_dead;
                    end else if (idx_r == idx_last) begin
                        state_s = st_snap;
                        idx_s   = '0;
                    end else begin
                        state_s = st_show;
                        idx_s   = idx_r + idx_one;
                    end
                end else begin
                    cnt_s = cnt_r + cnt_one;
                end
            end
            st_dead: begin
                if (cnt_r == dead_last) begin
                    cnt_s = '0;
                    if (idx_r == idx_last) begin
                        state_s = st_snap;
                        idx_s   = '0;
                    end else begin
                        state_s = st_show;
                        idx_s   = idx_r + idx_one;
                    end
                end else begin
                    cnt_s = cnt_r + cnt_one;
                end
            end
            default: begin
                state_s = st_snap;
                idx_s   = '0;
                cnt_s   = '0;
            end
        endcase
    end

    // Output decode from the current state; disabled slots stay blank
    always_comb begin
        digit_s       = '0;
        seg_s         = '0;
        frame_start_s = 1'b0;
        case (state_r)
            st_snap: begin
                frame_start_s = 1'b1;
            end
            st_show: begin
                if (shadow_en_r[idx_r]) begin
                    digit_s = onehot_f(idx_r);
                    seg_s   = shadow_hex_r[idx_r];
                end else begin
                    digit_s = '0;
                    seg_s   = '0;
                end
            end
            default: begin
                digit_s = '0;
                seg_s   = '0;
            end
        endcase
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            digit_r       <= '0;
            seg_r         <= '0;
            frame_start_r <= 1'b0;
        end else begin
            digit_r       <= digit_s;
            seg_r         <= seg_s;
            frame_start_r <= frame_start_s;
        end
    end

    // Frame snapshot: taken only in SNAP, skipped while freeze is high
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_hex_r <= '0;
            shadow_en_r  <= '0;
        end else if ((state_r == st_snap) && !freeze) begin
            shadow_hex_r <= hex;
            shadow_en_r  <= digit_en;
        end else begin
            shadow_hex_r <= shadow_hex_r;
            shadow_en_r  <= shadow_en_r;
        end
    end

    assign digit       = digit_r;
    assign hgfedcba    = seg_r;
    assign frame_start = frame_start_r;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux: a frame-level model queues expected
// per-cycle outputs; a negedge monitor pops and compares them.
module tb_seg_scan_mux;

    logic                 clk = 1'b0;
    logic                 rst_a, rst_b;
    logic [7:0][7:0]      hex_a, hex_b;
    logic [7:0]           en_a, en_b;
    logic                 freeze_a, freeze_b;
    logic [7:0]           digit_a, digit_b, seg_a, seg_b;
    logic                 fs_a, fs_b;

    int cmp_cnt  = 0;
    int fail_cnt = 0;

    always #5 clk = ~clk;

    seg_scan_mux #(.w_digit(8), .w_seg(8), .show_cycles(4), .dead_cycles(2)) dut_a (
        .clk(clk), .rst(rst_a), .hex(hex_a), .digit_en(en_a), .freeze(freeze_a),
        .digit(digit_a), .hgfedcba(seg_a), .frame_start(fs_a)
    );

    seg_scan_mux #(.w_digit(8), .w_seg(8), .show_cycles(1), .dead_cycles(0)) dut_b (
        .clk(clk), .rst(rst_b), .hex(hex_b), .digit_en(en_b), .freeze(freeze_b),
        .digit(digit_b), .hgfedcba(seg_b), .frame_start(fs_b)
    );

    typedef struct packed {
        logic       fs;
        logic [7:0] dig;
        logic [7:0] seg;
    } exp_t;

    exp_t       q[$];
    logic [7:0] mh [8];
    logic [7:0] me;

    // Frame layout: offset 0 is the SNAP pulse, then per digit 4 shown + 2 blank cycles
    function automatic exp_t exp_at(input int o);
        exp_t e;
        int   j, slot, ph;
        e = '0;
        if (o == 0) begin
            e.fs = 1'b1;
        end else begin
            j    = o - 1;
            slot = j / 6;
            ph   = j % 6;
            if (ph < 4 && me[slot]) begin
                e.dig = 8'(1 << slot);
                e.seg = mh[slot];
            end
        end
        return e;
    endfunction

    task automatic run_frame(input int mid_off, input logic [7:0] mid_val, input int rst_off);
        int n;
        @(posedge clk);
        if (!freeze_a) begin
            for (int i = 0; i < 8; i++) mh[i] = hex_a[i];
            me = en_a;
        end
        #1;
        n = (rst_off > 0) ? rst_off : 49;
        for (int o = 0; o < n; o++) q.push_back(exp_at(o));
        if (rst_off > 0) q.push_back(exp_t'(0));
        for (int k = 1; k <= ((rst_off > 0) ? rst_off : 48); k++) begin
            @(posedge clk);
            #1;
            if (k == mid_off) hex_a[3] = mid_val;
            if (rst_off > 0 && k == rst_off - 1) rst_a = 1'b1;
            if (rst_off > 0 && k == rst_off) begin
                rst_a = 1'b0;
                for (int i = 0; i < 8; i++) mh[i] = 8'h00;
                me = 8'h00;
            end
        end
    endtask

    // Scoreboard monitor for the 4/2 instance
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            cmp_cnt++;
            if ({fs_a, digit_a, seg_a} !== e) begin
                fail_cnt++;
                $display("FAIL scan_a t=%0t got fs=%b digit=%h seg=%h want fs=%b digit=%h seg=%h",
                         $time, fs_a, digit_a, seg_a, e.fs, e.dig, e.seg);
            end
        end
    end

    // Edge-config checker: 9-cycle frame, one digit per cycle, no blanking
    bit b_run = 1'b0;
    int b_pos = -1;
    always @(negedge clk) begin
        logic       w_fs;
        logic [7:0] w_dig, w_seg;
        if (b_run) begin
            if (b_pos < 0) begin
                if (fs_b) b_pos = 0;
            end else begin
                b_pos = (b_pos + 1) % 9;
            end
            if (b_pos >= 0) begin
                w_fs  = (b_pos == 0);
                w_dig = (b_pos == 0) ? 8'h00 : 8'(1 << (b_pos - 1));
                w_seg = (b_pos == 0) ? 8'h00 : hex_b[b_pos - 1];
                cmp_cnt++;
                if ({fs_b, digit_b, seg_b} !== {w_fs, w_dig, w_seg}) begin
                    fail_cnt++;
                    $display("FAIL scan_b t=%0t got fs=%b digit=%h seg=%h want fs=%b digit=%h seg=%h",
                             $time, fs_b, digit_b, seg_b, w_fs, w_dig, w_seg);
                end
            end
        end
    end

    // Strobes must never be multi-hot on either instance
    always @(negedge clk) begin
        if (b_run) begin
            cmp_cnt++;
            assert ($countones(digit_a) <= 1 && $countones(digit_b) <= 1)
            else begin
                fail_cnt++;
                $display("FAIL onehot t=%0t got digit_a=%h digit_b=%h want at most one bit set",
                         $time, digit_a, digit_b);
            end
        end
    end

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        freeze_a = 1'b0; freeze_b = 1'b0;
        en_a = 8'hFF; en_b = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            hex_a[i] = 8'h3F + 8'(i);
            hex_b[i] = 8'($urandom_range(1, 255));
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_a = 1'b0; rst_b = 1'b0;
        b_run = 1'b1;
        q.push_back(exp_t'(0));

        // Baseline frame, then alternating enables
        run_frame(0, 8'h00, 0);
        en_a = 8'b1010_1010;
        run_frame(0, 8'h00, 0);

        // Mid-frame update of hex[3] lands in the following frame
        en_a = 8'hFF;
        hex_a[3] = 8'h4F;
        run_frame(8, 8'h66, 0);
        run_frame(0, 8'h00, 0);

        // Frozen SNAP keeps old patterns; release picks up new ones
        freeze_a = 1'b1;
        for (int i = 0; i < 8; i++) hex_a[i] = 8'($urandom_range(0, 255));
        run_frame(0, 8'h00, 0);
        freeze_a = 1'b0;
        run_frame(0, 8'h00, 0);

        // Reset during blanking after digit 5, then a normal frame
        run_frame(0, 8'h00, 35);
        run_frame(0, 8'h00, 0);

        // Reset followed by a frozen SNAP shows a blank frame
        run_frame(0, 8'h00, 20);
        freeze_a = 1'b1;
        run_frame(0, 8'h00, 0);
        freeze_a = 1'b0;

        // Randomized frames
        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < 8; i++) hex_a[i] = 8'($urandom_range(0, 255));
            en_a     = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom_range(0, 255));
            freeze_a = ($urandom_range(0, 3) == 0);
            run_frame($urandom_range(1, 48), 8'($urandom_range(0, 255)), 0);
        end

        for (int t = 0; t < 200 && q.size() > 0; t++) @(negedge clk);
        @(negedge clk);
        cmp_cnt++;
        if (q.size() != 0) begin
            fail_cnt++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        cmp_cnt++;
        if (b_pos < 0) begin
            fail_cnt++;
            $display("FAIL sync_b got no frame_start want periodic frame_start");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule
